la_keeperbus: RTL
=================

LA_KEEPERBUS -- requirements
Module: la_keeperbus

Interface
REQ-001 The parameters SHALL be as follows, one per line:
- N, 8, bus width in bits (1..64).
- HOLD, 16, number of cycles the keeper drives after the external driver releases; 0 means drive indefinitely.
- RSTVAL, 0, value loaded into the keeper register at reset.
- PROP, "DEFAULT", implementation property string; has no functional effect.

REQ-002 The ports SHALL be as follows, one per line:
- clk  input  1  clock, rising edge.
- nreset  input  1  asynchronous active-low reset.
- z  inout  N  shared tri-state bus.
- ext_oe  input  1  an external agent is driving z this cycle.
- en  input  1  keeper enable.
- clr  input  1  synchronous clear of the sticky error flag.
- q  output  N  registered keeper value.
- valid  output  1  q holds a value captured from the bus since reset.
- hold  output  1  the keeper is currently driving z.
- timeout  output  1  the hold window expired.
- err  output  1  sticky flag: bus contention seen while holding.

REQ-003 Clock and reset SHALL be the single clock clk and asynchronous active-low reset nreset; no other clock domain exists in the block.

Function
REQ-004 The state machine SHALL have four states: IDLE, TRACK, HOLD and EXPIRED, encoded in 2 bits.
REQ-005 From any state, en=0 at a clock edge SHALL move the machine to IDLE; z SHALL NOT be driven while en=0.
REQ-006 In any state with en=1, ext_oe=1 at a clock edge SHALL move the machine to TRACK, load q with z, set valid=1 and clear the hold counter.
REQ-007 From TRACK, ext_oe=0 at an edge SHALL move the machine to HOLD if valid=1, otherwise to IDLE.
REQ-008 In HOLD, the hold counter (width clog2(HOLD+1), minimum 1 bit) SHALL increment once per cycle.
REQ-009 When HOLD>0 and the counter reaches HOLD-1, the machine SHALL move to EXPIRED at the next edge; with HOLD=0 the counter SHALL never wrap and HOLD SHALL persist.
REQ-010 In EXPIRED, the machine SHALL stay there, with z undriven, until ext_oe=1 or en=0.
REQ-011 z SHALL be driven with q if and only if state==HOLD and ext_oe==0; otherwise z SHALL be high-impedance on all N bits.
REQ-012 The drive release on ext_oe rising SHALL be combinational, with zero cycles overlap.
REQ-013 hold SHALL equal the z drive-enable term exactly.
REQ-014 timeout SHALL be 1 if and only if state==EXPIRED.
REQ-015 err SHALL set at an edge where state==HOLD, ext_oe==0 and z!=q (detecting a foreign driver).
REQ-016 err SHALL clear when clr=1 at an edge; if set and clear conditions occur together, set SHALL win.
REQ-017 Any z bit sampled as X or Z in TRACK SHALL be stored as-is in simulation; no correction is performed.
REQ-018 q SHALL change only on TRACK capture or reset.

Reset
REQ-019 On nreset low, the block SHALL immediately, without waiting for clk, set state=IDLE, q=RSTVAL, valid=0, counter=0 and err=0, and release z.
REQ-020 After reset, hold=0 and timeout=0 SHALL follow from state IDLE.
REQ-021 Deassertion of nreset SHALL be synchronised externally; the first active edge after deassertion SHALL follow the rules above.
REQ-022 Reset asserted mid-HOLD SHALL release z in the same time step and discard q.

Verification
REQ-023 N=8, HOLD=4: drive z=8'hA5 with ext_oe=1 for 2 cycles, then ext_oe=0 -> z reads 8'hA5 for exactly 4 cycles with hold=1, then z=Z, timeout=1, q stays 8'hA5.
REQ-024 HOLD=0: capture 8'h3C, release ext_oe, run 1000 cycles -> z stays 8'h3C, timeout stays 0.
REQ-025 While in HOLD, raise ext_oe with z=8'h0F -> keeper releases in the same cycle (no contention), q=8'h0F at the next edge, counter restarts on the following release.
REQ-026 While in HOLD, force z=8'hFF from an external source with ext_oe=0 and q=8'h00 -> err=1 at the next edge, stays 1 until clr pulse; with clr and contention in the same cycle, err stays 1.
REQ-027 Drop nreset for half a clock during HOLD -> z=Z immediately, q=RSTVAL, valid=0; after release with ext_oe=0, state stays IDLE and z stays undriven.
REQ-028 en=0 during TRACK, then ext_oe=0 -> no drive, state IDLE; en=1 with ext_oe=0 and valid=1 -> remains IDLE until a new capture.

Source files
------------

// File: rtl/la_keeperbus.sv
// Bus keeper for a shared tri-state bus: tracks the value an external agent drives,
// then re-drives it for a bounded hold window after the agent releases the bus.
module la_keeperbus #(
  parameter int          N      = 8,
  parameter int          HOLD   = 16,
  parameter logic [N-1:0] RSTVAL = '0,
  parameter              PROP   = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  inout  wire  [N-1:0] z,
  input  logic         ext_oe,
  input  logic         en,
  input  logic         clr,
  output logic [N-1:0] q,
  output logic         valid,
  output logic         hold,
  output logic         timeout,
  output logic         err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TRACK   = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  // HOLD=0 still needs a 1-bit counter; it saturates instead of wrapping.
  localparam int            CW       = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((HOLD > 0) ? HOLD - 1 : 0);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          drive;
  logic          hold_last;
  logic          capture;
  logic          contention;

  // The implementation property string carries no function.
  logic unused_prop;
  assign unused_prop = ^PROP;

  assign capture   = en && ext_oe;
  assign hold_last = (HOLD != 0) && (cnt == CNT_LAST);

  // Drive release follows ext_oe combinationally so there is never a cycle of overlap.
  assign drive   = en && !ext_oe && (state == S_HOLD);
  assign z       = drive ? q : {N{1'bz}};
  assign hold    = drive;
  assign timeout = (state == S_EXPIRED);

  // Case-inequality so an X produced by a fighting driver also counts as contention.
  assign contention = drive && (z !== q);

  always_comb begin
    // NOTE: default assignment first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (!en) begin
      state_nxt = S_IDLE;
    end else if (ext_oe) begin
      state_nxt = S_TRACK;
    end else begin
      case (state)
        S_TRACK: state_nxt = valid ? S_HOLD : S_IDLE;
        S_HOLD:  if (hold_last) state_nxt = S_EXPIRED;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= S_IDLE;
      q     <= RSTVAL;
      valid <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (capture) begin
        q     <= z;
        valid <= 1'b1;
        cnt   <= '0;
      end else if (en && (state == S_HOLD) && (cnt != {CW{1'b1}})) begin
        cnt <= cnt + CW'(1);
      end
      if (contention) begin
        err <= 1'b1;
      end else if (clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule
